sram_port_arbiter: RTL

Shares a single SRAM-like memory port between the instruction-fetch requester and the data-access requester of the 6-stage core. It sits between the IF/EX/MEM stages and the memory bridge. It arbitrates request issue, holds a grant until the address handshake completes, and tracks outstanding transactions in issue order. Each returned `data_ok`/`rdata` is routed back to the requester that issued it.

---
 rtl/sram_port_arbiter_pkg.sv | 25 ++
 rtl/sram_port_arbiter_id_fifo.sv | 68 ++++++
 rtl/sram_port_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared source IDs, grant states and request-bundle packing for sram_port_arbiter
package sram_port_arbiter_pkg;

    localparam logic ARB_SRC_INST   = 1'b0;
    localparam logic ARB_SRC_DATA   = 1'b1;
    localparam int   ARB_REQ_BUS_WD = 71;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_INST = 2'd1,
        ST_HOLD_DATA = 2'd2
    } arb_state_e;

    // Bundle order matches the mem_* field order: wr, size, addr, wstrb, wdata.
    function automatic logic [ARB_REQ_BUS_WD-1:0] pack_req(
        input logic        wr,
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [3:0]  wstrb,
        input logic [31:0] wdata
    );
        return {wr, size, addr, wstrb, wdata};
    endfunction

endpackage

// File: rtl/sram_port_arbiter_id_fifo.sv
// rtl/sram_port_arbiter_id_fifo.sv - arb_id_fifo: 1-bit source-ID FIFO of issued transactions with a registered full flag
module arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] ids_q, ids_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & (count_q != '0);

    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            ids_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        // Registering full keeps mem_data_ok off the combinational mem_req path.
        full_d = (count_d == (PW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ids_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ids_q    <= ids_d;
            full_q   <= full_d;
        end
    end

    assign head  = ids_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - inst/data arbiter onto one SRAM-like port with in-order response routing
// Optional inst starvation guard: define ARB_STARVE_GUARD_EN.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    arb_state_e                state_q, state_d;
    logic [ARB_REQ_BUS_WD-1:0] inst_bus, data_bus, mem_bus;
    logic                      gnt_src, gnt_active, src_req, hs;
    logic                      fifo_full, fifo_empty, fifo_head;
    logic                      force_inst, rsp_valid;

    assign inst_bus = pack_req(inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata);
    assign data_bus = pack_req(data_wr, data_size, data_addr, data_wstrb, data_wdata);

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (hs && gnt_src == ARB_SRC_INST) begin
            starve_d = '0;
        end else if (hs && gnt_src == ARB_SRC_DATA && inst_req && starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_inst = inst_req & (starve_q == LIMIT);
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign force_inst          = 1'b0;
`endif

    always_comb begin
        gnt_src    = ARB_SRC_INST;
        gnt_active = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                gnt_src    = (data_req && !force_inst) ? ARB_SRC_DATA : ARB_SRC_INST;
                gnt_active = (inst_req | data_req) & ~fifo_full;
            end
            ST_HOLD_INST: begin
                gnt_src    = ARB_SRC_INST;
                gnt_active = 1'b1;
            end
            ST_HOLD_DATA: begin
                gnt_src    = ARB_SRC_DATA;
                gnt_active = 1'b1;
            end
            default: begin
                gnt_src    = ARB_SRC_INST;
                gnt_active = 1'b0;
            end
        endcase
        // Outputs collapse while reset is held even though requesters may still be active.
        gnt_active = gnt_active & resetn;
        src_req    = (gnt_src == ARB_SRC_DATA) ? data_req : inst_req;
        mem_req    = gnt_active & src_req & ~fifo_full;
        mem_bus    = '0;
        if (gnt_active) begin
            mem_bus = (gnt_src == ARB_SRC_DATA) ? data_bus : inst_bus;
        end
        hs = mem_req & mem_addr_ok;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_d = (gnt_src == ARB_SRC_DATA) ? ST_HOLD_DATA : ST_HOLD_INST;
                end
            end
            ST_HOLD_INST, ST_HOLD_DATA: begin
                if (hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} = mem_bus;

    assign inst_addr_ok = hs & (gnt_src == ARB_SRC_INST);
    assign data_addr_ok = hs & (gnt_src == ARB_SRC_DATA);

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs),
        .pop    (mem_data_ok),
        .din    (gnt_src),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A response with nothing outstanding is dropped rather than misrouted.
    assign rsp_valid    = mem_data_ok & ~fifo_empty;
    assign inst_data_ok = rsp_valid & (fifo_head == ARB_SRC_INST);
    assign data_data_ok = rsp_valid & (fifo_head == ARB_SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(mem_data_ok && fifo_empty))
                else $error("mem_data_ok with no outstanding transaction");
        end
    end
`endif

endmodule
